// File: rtl/lp_fp_div_result_buf.sv
// Result buffer placed behind the low-power pipelined FP divider.
// Captures each pushed result {z, status, arrive_id} into a circular buffer.
// Drives accept_n back-pressure from the registered fill level.
// Serves the head entry over valid/ready.
// Tracks launch-order IDs and raises sticky sequence/overflow error flags.
module lp_fp_div_result_buf #(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int id_width  = 8,
  parameter int depth     = 4,
  parameter int cnt_width = 3,
  parameter int id_check  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 arrive,
  input  logic                                 push_out_n,
  input  logic [sig_width+exp_width:0]         z,
  input  logic [7:0]                           status,
  input  logic [id_width-1:0]                  arrive_id,
  output logic                                 accept_n,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [sig_width+exp_width:0]         out_z,
  output logic [7:0]                           out_status,
  output logic [id_width-1:0]                  out_id,
  output logic [cnt_width-1:0]                 level,
  input  logic                                 clr_err,
  output logic                                 seq_err,
  output logic                                 ovf_err
);

  localparam int DW = sig_width + exp_width + 1;
  localparam int EW = DW + 8 + id_width;
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [PW-1:0]        LAST_PTR = PW'(depth - 1);
  localparam logic [cnt_width-1:0] FULL_LVL = cnt_width'(depth);

  logic [EW-1:0]        mem_q [depth];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [cnt_width-1:0] level_q, level_d;
  logic [id_width-1:0]  exp_id_q, exp_id_d;
  logic                 seq_err_q, seq_err_d;
  logic                 ovf_err_q, ovf_err_d;

  logic                 full, empty, push, pop, wr_en;
  logic [EW-1:0]        head;
  logic                 unused_arrive;

  // arrive only mirrors the divider's own valid; capture is keyed on push_out_n
  assign unused_arrive = arrive;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign push  = ~push_out_n;
  assign pop   = ~empty & out_ready;
  assign wr_en = push & ~full;

  // Next-state for pointers, level, expected ID and sticky error flags
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    exp_id_d  = exp_id_q;
    seq_err_d = seq_err_q;
    ovf_err_d = ovf_err_q;

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    if (wr_en && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!wr_en && pop) begin
      level_d = level_q - 1'b1;
    end

    // A full buffer drops the result; its ID is not checked either
    if (push && full) begin
      ovf_err_d = 1'b1;
    end

    // Mismatch resyncs to the arriving ID so one gap reports only once
    if (wr_en && !clr_err && (id_check != 0)) begin
      if (arrive_id == exp_id_q) begin
        exp_id_d = exp_id_q + 1'b1;
      end else begin
        seq_err_d = 1'b1;
        exp_id_d  = arrive_id + 1'b1;
      end
    end

    // Clear wins over any error raised in the same cycle
    if (clr_err) begin
      seq_err_d = 1'b0;
      ovf_err_d = 1'b0;
      exp_id_d  = '0;
    end
  end

  // Control state register; storage is deliberately outside the reset domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      exp_id_q  <= '0;
      seq_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      exp_id_q  <= exp_id_d;
      seq_err_q <= seq_err_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  // Entry storage write; no reset so it can map onto plain registers/RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {z, status, arrive_id};
    end
  end

  // Fall-through read: head entry is visible the cycle after it was written
  assign head       = mem_q[rd_ptr_q];
  assign out_z      = head[EW-1 -: DW];
  assign out_status = head[id_width+7 -: 8];
  assign out_id     = head[id_width-1:0];

  assign out_valid  = ~empty;
  assign accept_n   = full;
  assign level      = level_q;
  assign seq_err    = seq_err_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_lp_fp_div_result_buf.sv
// Self-checking bench for lp_fp_div_result_buf: directed scenarios plus
// randomized traffic, checked each cycle against a queue-based model.
module tb_lp_fp_div_result_buf;

  localparam int SW    = 23;
  localparam int EXW   = 8;
  localparam int IDW   = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int DW    = SW + EXW + 1;

  logic           clk;
  logic           rst_n;
  logic           arrive;
  logic           push_out_n;
  logic [DW-1:0]  z;
  logic [7:0]     status;
  logic [IDW-1:0] arrive_id;
  logic           accept_n;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_z;
  logic [7:0]     out_status;
  logic [IDW-1:0] out_id;
  logic [CW-1:0]  level;
  logic           clr_err;
  logic           seq_err;
  logic           ovf_err;

  lp_fp_div_result_buf #(
    .sig_width(SW), .exp_width(EXW), .id_width(IDW),
    .depth(DEPTH), .cnt_width(CW), .id_check(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arrive(arrive), .push_out_n(push_out_n),
    .z(z), .status(status), .arrive_id(arrive_id), .accept_n(accept_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_status(out_status), .out_id(out_id), .level(level),
    .clr_err(clr_err), .seq_err(seq_err), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: FIFO of results, expected ID, sticky flags
  typedef struct {
    logic [DW-1:0]  z;
    logic [7:0]     st;
    logic [IDW-1:0] id;
  } entry_t;

  entry_t         m_q[$];
  logic [IDW-1:0] m_exp;
  logic           m_seq;
  logic           m_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_exp = '0;
    m_seq = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_update(input logic p, input logic [DW-1:0] zz, input logic [7:0] st,
                              input logic [IDW-1:0] id, input logic rdy, input logic clr);
    entry_t e;
    bit     was_full;
    bit     do_pop;
    was_full = (m_q.size() == DEPTH);
    do_pop   = (m_q.size() != 0) && rdy;
    if (p) begin
      if (was_full) begin
        m_ovf = 1'b1;
      end else begin
        e.z = zz; e.st = st; e.id = id;
        m_q.push_back(e);
        if (!clr) begin
          if (id != m_exp) m_seq = 1'b1;
          m_exp = id + 1'b1;
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (clr) begin
      m_seq = 1'b0;
      m_ovf = 1'b0;
      m_exp = '0;
    end
  endtask

  // One clock of stimulus; model advances on the same edge as the DUT
  task automatic step(input logic p, input logic [IDW-1:0] id, input logic rdy, input logic clr);
    push_out_n = ~p;
    arrive     = p ^ ($urandom_range(0, 7) == 0);
    arrive_id  = id;
    z          = $urandom;
    status     = 8'($urandom);
    out_ready  = rdy;
    clr_err    = clr;
    @(posedge clk);
    if (rst_n) model_update(p, z, status, id, rdy, clr);
    #1;
  endtask

  // Compare process: every cycle outside reset, DUT against model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("level",     64'(level),     64'(m_q.size()));
        chk("accept_n",  64'(accept_n),  64'(m_q.size() == DEPTH));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("seq_err",   64'(seq_err),   64'(m_seq));
        chk("ovf_err",   64'(ovf_err),   64'(m_ovf));
        if (m_q.size() != 0) begin
          chk("out_z",      64'(out_z),      64'(m_q[0].z));
          chk("out_status", 64'(out_status), 64'(m_q[0].st));
          chk("out_id",     64'(out_id),     64'(m_q[0].id));
        end
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    push_out_n = 1'b1; arrive = 1'b0; arrive_id = '0; z = '0; status = '0;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_accept_n",  64'(accept_n),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_errs",      64'({seq_err, ovf_err}), 64'd0);

    // Three in-order pushes, consumer stalled
    step(1, 8'd0, 0, 0);
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_id",    64'(out_id),    64'd0);
    step(1, 8'd1, 0, 0);
    step(1, 8'd2, 0, 0);
    chk("three_level",    64'(level),    64'd3);
    chk("three_accept_n", 64'(accept_n), 64'd0);
    chk("three_seq",      64'(seq_err),  64'd0);

    // Fill, then overflow
    step(1, 8'd3, 0, 0);
    chk("full_accept_n", 64'(accept_n), 64'd1);
    step(1, 8'd4, 0, 0);
    chk("ovf_flag",  64'(ovf_err), 64'd1);
    chk("ovf_level", 64'(level),   64'd4);
    chk("ovf_head",  64'(out_id),  64'd0);
    // Single pop from full: accept_n drops after the edge
    step(0, 8'd0, 1, 0);
    chk("pop_accept_n", 64'(accept_n), 64'd0);
    chk("pop_level",    64'(level),    64'd3);
    chk("pop_head",     64'(out_id),   64'd1);

    // Drain and clear
    repeat (4) step(0, 8'd0, 1, 0);
    step(0, 8'd0, 1, 1);
    chk("clr_ovf", 64'(ovf_err), 64'd0);

    // Streaming push+pop, IDs 0..19
    for (int i = 0; i < 20; i++) step(1, IDW'(i), 1, 0);
    chk("stream_level", 64'(level),   64'd1);
    chk("stream_head",  64'(out_id),  64'd19);
    chk("stream_seq",   64'(seq_err), 64'd0);
    step(0, 8'd0, 1, 1);

    // Out-of-order: 0,1,3,4
    step(1, 8'd0, 1, 0);
    step(1, 8'd1, 1, 0);
    chk("gap_noerr_yet", 64'(seq_err), 64'd0);
    step(1, 8'd3, 1, 0);
    chk("gap_seq", 64'(seq_err), 64'd1);
    step(1, 8'd4, 1, 0);
    step(0, 8'd0, 1, 1);
    chk("gap_clr", 64'(seq_err), 64'd0);
    // Push together with clear: check skipped, next expected ID is 0
    step(1, 8'd7, 1, 1);
    step(1, 8'd0, 1, 0);
    chk("clr_push_exp0", 64'(seq_err), 64'd0);

    // Run IDs up through 255 and wrap to 0
    for (int i = 1; i < 256; i++) step(1, IDW'(i), 1, 0);
    step(1, 8'd0, 1, 0);
    chk("wrap_seq", 64'(seq_err), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [IDW-1:0] rid;
      rid = ($urandom_range(0, 9) == 0) ? IDW'($urandom) : m_exp;
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rid,
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    // Mid-stream reset with buffered entries and raised error
    repeat (4) step(0, 8'd0, 1, 0);
    step(0, 8'd0, 1, 1);
    step(1, 8'd9, 0, 0);
    step(1, 8'd10, 0, 0);
    step(1, 8'd11, 0, 0);
    chk("pre_rst_level", 64'(level),   64'd3);
    chk("pre_rst_seq",   64'(seq_err), 64'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_level",     64'(level),     64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_accept_n",  64'(accept_n),  64'd0);
    chk("mid_rst_errs",      64'({seq_err, ovf_err}), 64'd0);
    step(1, 8'd5, 0, 0);
    rst_n = 1'b1;
    step(1, 8'd0, 0, 0);
    step(1, 8'd1, 0, 0);
    chk("post_rst_level", 64'(level),   64'd2);
    chk("post_rst_head",  64'(out_id),  64'd0);
    chk("post_rst_seq",   64'(seq_err), 64'd0);
    repeat (3) step(0, 8'd0, 1, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lp_fp_div_result_buf.md
Name: lp_fp_div_result_buf

Overview:
- Output-side stage placed directly downstream of the low-power pipelined FP divider.
- Captures each result the divider pushes out (z, status, arrive_id) into a small circular buffer and drives the divider's accept_n as back-pressure.
- Presents results to the consumer over a valid/ready interface.
- Checks that result IDs arrive in launch order and raises sticky error flags on ID mismatch or on a push into a full buffer.

Parameters:
- sig_width, 23, FP significand width; data width DW = sig_width+exp_width+1.
- exp_width, 8, FP exponent width.
- id_width, 8, width of launch/arrive ID.
- depth, 4, buffer entries; legal range 2..16.
- cnt_width, 3, width of level counter; must satisfy 2^cnt_width > depth.
- id_check, 1, 1 = enable in-order ID check; 0 = seq_err tied 0.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- arrive, in, 1, divider output stage holds a valid result.
- push_out_n, in, 1, active-low; result transferred into this block this cycle.
- z, in, DW, divider result.
- status, in, 8, divider status flags.
- arrive_id, in, id_width, ID of the arriving result.
- accept_n, out, 1, to divider; 1 = buffer cannot accept.
- out_valid, out, 1, head entry valid.
- out_ready, in, 1, consumer takes head entry when out_valid & out_ready.
- out_z, out, DW, head result.
- out_status, out, 8, head status.
- out_id, out, id_width, head ID.
- level, out, cnt_width, current entry count.
- clr_err, in, 1, synchronous clear of sticky errors and the expected-ID counter.
- seq_err, out, 1, sticky: out-of-order ID seen.
- ovf_err, out, 1, sticky: push while full.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=rd_ptr=0, level=0, exp_id=0, accept_n=0, out_valid=0, seq_err=0, ovf_err=0. Storage array is not reset; out_z/out_status/out_id are don't-care while out_valid=0.
- A reset asserted mid-operation discards all buffered entries immediately.
- push = ~push_out_n. arrive is informational only; a push with arrive=0 is still captured.
- pop = out_valid & out_ready.
- accept_n = (level == depth), derived from the registered level with no combinational path from out_ready.
  - When full and a pop occurs, accept_n stays 1 that cycle and falls the next cycle.
- Push, not full: write {z,status,arrive_id} to mem[wr_ptr]; wr_ptr wraps depth-1 -> 0.
- Push while full: data dropped, pointers and level unchanged, ovf_err <= 1.
- Pop: rd_ptr advances with wrap; a pop while empty is impossible because out_valid=0.
- Simultaneous push and pop (not full): level unchanged, both pointers advance.
- level: +1 on push only, -1 on pop only.
- Latency: data pushed in cycle t appears on out_* with out_valid=1 in cycle t+1. No same-cycle bypass.
- out_valid = (level != 0). out_* are driven combinationally from mem[rd_ptr] (fall-through read of registered storage).
- ID check (id_check=1), on each accepted push:
  - arrive_id == exp_id: exp_id <= exp_id+1, modulo 2^id_width (wraps all-ones -> 0).
  - arrive_id != exp_id: seq_err <= 1 and exp_id <= arrive_id+1 (resync).
  - A dropped push (full) does not update exp_id.
- clr_err=1: seq_err <= 0, ovf_err <= 0, exp_id <= 0 that edge.
  - A push in the same cycle is stored but its ID check is skipped; exp_id then becomes 0, not 1.
  - Buffer contents are untouched.
- No FSM beyond the pointer/level logic. Full and empty are exactly level==depth and level==0.

Test Plan:
- Reset, then push IDs 0,1,2 on consecutive cycles with out_ready=0 -> level=3, accept_n=0, out_id=0 from cycle 1 after the first push, seq_err=0.
- Push 4 entries with depth=4 and out_ready=0 -> accept_n=1 after the 4th; a forced 5th push -> ovf_err=1, level=4, contents unchanged. Pop once -> accept_n=0 the following cycle.
- Continuous push+pop for 20 cycles with IDs 0..19 -> level constant at 1, output IDs in order, pointers wrap without loss.
- Push IDs 0,1,3,4 -> seq_err=1 on the ID-3 push, no further error on ID 4. Pulse clr_err -> seq_err=0 and next expected ID=0.
- id_width=8, push IDs 254,255,0 after resync -> no seq_err across the 255->0 wrap.
- Fill to 3 entries, assert rst_n=0 mid-stream -> level=0, out_valid=0, accept_n=0 immediately; errors cleared.
